// File: rtl/sysref_gate_ctrl.sv
// Measures captured SYSREF period until stable, then passes a programmed
// number of whole pulses to the converter sync inputs and closes the gate.
module sysref_gate_ctrl #(
    parameter int CNT_W    = 16,
    parameter int TOL      = 1,
    parameter int STABLE   = 4,
    parameter int MAX_MISS = 8,
    parameter int TIMEOUT  = 65535
) (
    input  logic             pl_clk,
    input  logic             pl_rst,
    input  logic             sysref_in,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       release_count,
    output logic             sysref_gated,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] period
);

    localparam int MW = $clog2(STABLE + 1);
    localparam int XW = $clog2(MAX_MISS + 1);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
    localparam logic [MW-1:0]    STABLE_C = MW'(STABLE);
    localparam logic [XW-1:0]    MISS_C   = XW'(MAX_MISS);

    typedef enum logic [2:0] {
        S_IDLE, S_MEASURE, S_GATE, S_DONE, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic             sysref_d_q, sysref_d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic [MW-1:0]    match_q, match_d;
    logic [XW-1:0]    miss_q, miss_d;
    logic             arm_q, arm_d;
    logic             ref_vld_q, ref_vld_d;
    logic [7:0]       rel_q, rel_d;
    logic [7:0]       pulse_q, pulse_d;
    logic             pass_q, pass_d;
    logic             locked_q, locked_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             gated_q, gated_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             rise, fall, in_tol;
    logic [CNT_W-1:0] diff;
    logic [MW-1:0]    match_nxt;
    logic [XW-1:0]    miss_nxt;

    assign rise      = sysref_in & ~sysref_d_q;
    assign fall      = ~sysref_in & sysref_d_q;
    assign diff      = (cnt_q >= ref_q) ? cnt_q - ref_q : ref_q - cnt_q;
    assign in_tol    = (diff <= TOL_C);
    assign match_nxt = match_q + 1'b1;
    assign miss_nxt  = miss_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        sysref_d_d = sysref_in;
        ref_d      = ref_q;
        match_d    = match_q;
        miss_d     = miss_q;
        arm_d      = arm_q;
        ref_vld_d  = ref_vld_q;
        rel_d      = rel_q;
        pulse_d    = pulse_q;
        pass_d     = pass_q;
        locked_d   = locked_q;
        code_d     = code_q;
        period_d   = period_q;
        if (rise) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_q != TMO) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d   = S_MEASURE;
                    rel_d     = release_count;
                    locked_d  = 1'b0;
                    code_d    = 2'd0;
                    match_d   = '0;
                    miss_d    = '0;
                    arm_d     = 1'b0;
                    ref_vld_d = 1'b0;
                    pulse_d   = '0;
                    pass_d    = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_MEASURE: begin
                if (cnt_q == TMO) begin
                    state_d = S_ERR;
                    code_d  = 2'd1;
                end else if (rise) begin
                    if (!arm_q) begin
                        arm_d = 1'b1;
                    end else if (!ref_vld_q) begin
                        ref_vld_d = 1'b1;
                        ref_d     = cnt_q;
                        match_d   = '0;
                    end else if (in_tol) begin
                        match_d = match_nxt;
                        if (match_nxt == STABLE_C) begin
                            locked_d = 1'b1;
                            period_d = ref_q;
                            state_d  = (rel_q == 8'd0) ? S_DONE : S_GATE;
                        end
                    end else begin
                        ref_d   = cnt_q;
                        match_d = '0;
                        miss_d  = miss_nxt;
                        if (miss_nxt == MISS_C) begin
                            state_d = S_ERR;
                            code_d  = 2'd2;
                        end
                    end
                end
            end
            S_GATE: begin
                if (cnt_q == TMO) begin
                    state_d = S_ERR;
                    code_d  = 2'd1;
                end else if (rise && !in_tol) begin
                    state_d = S_ERR;
                    code_d  = 2'd3;
                end else begin
                    // Open only on a low input so the lock pulse is never cut.
                    if (!pass_q && !sysref_in) pass_d = 1'b1;
                    if (pass_q && rise) pulse_d = pulse_q + 1'b1;
                    if (pass_q && fall && pulse_q == rel_q) begin
                        pass_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ERR && state_q != S_ERR) begin
            locked_d = 1'b0;
            pass_d   = 1'b0;
        end
        if (abort) begin
            state_d  = S_IDLE;
            pass_d   = 1'b0;
            locked_d = 1'b0;
            code_d   = 2'd0;
        end

        // Gate closes in the same cycle the sequence leaves GATE.
        gated_d = sysref_in & pass_q & (state_q == S_GATE)
                & (state_d == S_GATE);
        busy_d  = (state_d == S_MEASURE) || (state_d == S_GATE);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
    end

    always_ff @(posedge pl_clk) begin
        if (pl_rst) begin
            state_q    <= S_IDLE;
            sysref_d_q <= 1'b0;
            cnt_q      <= '0;
            ref_q      <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            arm_q      <= 1'b0;
            ref_vld_q  <= 1'b0;
            rel_q      <= '0;
            pulse_q    <= '0;
            pass_q     <= 1'b0;
            locked_q   <= 1'b0;
            code_q     <= 2'd0;
            period_q   <= '0;
            gated_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sysref_d_q <= sysref_d_d;
            cnt_q      <= cnt_d;
            ref_q      <= ref_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            arm_q      <= arm_d;
            ref_vld_q  <= ref_vld_d;
            rel_q      <= rel_d;
            pulse_q    <= pulse_d;
            pass_q     <= pass_d;
            locked_q   <= locked_d;
            code_q     <= code_d;
            period_q   <= period_d;
            gated_q    <= gated_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign sysref_gated = gated_q;
    assign busy         = busy_q;
    assign locked       = locked_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = code_q;
    assign period       = period_q;

endmodule

// File: tb/tb_sysref_gate_ctrl.sv
// Directed bench for sysref_gate_ctrl: SYSREF pulse trains in, gated
// pulses scoreboarded by start cycle and width.
module tb_sysref_gate_ctrl;

    logic        pl_clk = 1'b0;
    logic        pl_rst = 1'b1;
    logic        sysref_in = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  release_count = 8'd0;
    logic        sysref_gated;
    logic        busy, locked, done, error;
    logic [1:0]  err_code;
    logic [15:0] period;

    sysref_gate_ctrl #(
        .CNT_W(16), .TOL(1), .STABLE(4), .MAX_MISS(8), .TIMEOUT(100)
    ) dut (
        .pl_clk(pl_clk), .pl_rst(pl_rst), .sysref_in(sysref_in),
        .start(start), .abort(abort), .release_count(release_count),
        .sysref_gated(sysref_gated), .busy(busy), .locked(locked),
        .done(done), .error(error), .err_code(err_code), .period(period)
    );

    always #5 pl_clk = ~pl_clk;

    typedef struct { int t; int w; } ev_t;
    ev_t exp_q[$];
    ev_t obs_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ot = 0, ow = 0;
    logic pg = 1'b0;
    int rise_cyc;
    logic b_locked, a_locked, a_error, a_done;
    logic [1:0] a_code;
    logic [15:0] a_period;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: drive input, sample outputs 1 time unit after the edge.
    task automatic step(input logic s);
        sysref_in = s;
        @(posedge pl_clk);
        #1;
        cyc++;
        if (sysref_gated && !pg) begin ot = cyc; ow = 0; end
        if (sysref_gated) ow++;
        if (!sysref_gated && pg) obs_q.push_back('{t: ot, w: ow});
        pg = sysref_gated;
    endtask

    task automatic sr(input int per, input int high, input bit push);
        b_locked = locked;
        step(1'b1);
        rise_cyc = cyc;
        a_locked = locked;
        a_error  = error;
        a_code   = err_code;
        a_done   = done;
        a_period = period;
        for (int i = 1; i < per; i++) step(i < high);
        if (push) exp_q.push_back('{t: rise_cyc, w: high});
    endtask

    task automatic go(input logic [7:0] rc);
        release_count = rc;
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_err", error, 0);
    endtask

    task automatic lock32(input string tag);
        for (int i = 0; i < 5; i++) sr(32, 4, 0);
        sr(32, 4, 0);
        chk({tag, "_pre"}, b_locked, 0);
        chk({tag, "_lock"}, a_locked, 1);
        chk({tag, "_per"}, a_period, 32);
    endtask

    task automatic sb_cmp(input string tag);
        ev_t e, o;
        chk({tag, "_n"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_t"}, o.t, e.t);
            chk({tag, "_w"}, o.w, e.w);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        // Reset
        step(1'b0);
        step(1'b0);
        pl_rst = 1'b0;
        step(1'b0);
        chk("rst_gated", sysref_gated, 0);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_code", err_code, 0);
        chk("rst_period", period, 0);

        // Abort wins over start
        start = 1'b1; abort = 1'b1;
        step(1'b0);
        start = 1'b0; abort = 1'b0;
        chk("abort_prio", busy, 0);

        // Lock and pass 3 pulses
        go(8'd3);
        lock32("t1");
        chk("t1_gate_busy", busy, 1);
        sr(32, 4, 1);
        sr(32, 4, 1);
        sr(32, 4, 1);
        chk("t1_done_late", a_done, 0);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_locked", locked, 1);
        for (int i = 0; i < 10; i++) sr(32, 4, 0);
        chk("t1_done_hold", done, 1);
        sb_cmp("t1_sb");

        // Reload on 35, then lock at 35; release_count 0
        go(8'd0);
        sr(32, 4, 0); sr(33, 4, 0); sr(35, 4, 0); sr(34, 4, 0);
        sr(36, 4, 0); sr(35, 4, 0); sr(35, 4, 0);
        sr(32, 4, 0);
        chk("t2a_pre", b_locked, 0);
        chk("t2a_lock", a_locked, 1);
        chk("t2a_per", a_period, 35);
        chk("t2a_done", a_done, 1);

        // Jitter within tolerance
        go(8'd0);
        sr(32, 4, 0); sr(33, 4, 0); sr(31, 4, 0);
        sr(32, 4, 0); sr(33, 4, 0);
        sr(32, 4, 0);
        chk("t2b_pre", b_locked, 0);
        chk("t2b_lock", a_locked, 1);
        chk("t2b_per", a_period, 32);
        chk("t2b_done", a_done, 1);
        sb_cmp("t2_sb");

        // No lock: alternating 20/40
        go(8'd3);
        for (int i = 1; i <= 9; i++) sr((i % 2) ? 20 : 40, 4, 0);
        chk("t3_err_early", a_error, 0);
        sr(40, 4, 0);
        chk("t3_err", a_error, 1);
        chk("t3_code", a_code, 2);
        chk("t3_hold", error, 1);
        sb_cmp("t3_sb");

        // Timeout in GATE
        go(8'd5);
        lock32("t4");
        sr(32, 4, 1);
        sr(32, 4, 1);
        r = rise_cyc;
        while (!error && cyc < r + 300) step(1'b0);
        chk("t4_lat", cyc - r, 100);
        chk("t4_code", err_code, 1);
        chk("t4_locked", locked, 0);
        chk("t4_busy", busy, 0);
        sb_cmp("t4_sb");

        // Drift in GATE
        go(8'd5);
        lock32("t5");
        sr(32, 4, 1);
        sr(40, 4, 1);
        sr(32, 4, 0);
        chk("t5_err", a_error, 1);
        chk("t5_code", a_code, 3);
        chk("t5_locked", a_locked, 0);
        sb_cmp("t5_sb");

        // Abort mid-pulse
        go(8'd5);
        lock32("t6");
        sr(32, 4, 1);
        step(1'b1);
        r = cyc;
        step(1'b1);
        abort = 1'b1;
        step(1'b1);
        abort = 1'b0;
        chk("t6_gated", sysref_gated, 0);
        chk("t6_busy", busy, 0);
        chk("t6_locked", locked, 0);
        chk("t6_code", err_code, 0);
        exp_q.push_back('{t: r, w: 2});
        step(1'b1);
        for (int i = 0; i < 28; i++) step(1'b0);
        for (int i = 0; i < 3; i++) sr(32, 4, 0);
        chk("t6_idle", busy, 0);
        sb_cmp("t6_sb");

        // Reset mid-pulse
        go(8'd5);
        lock32("t7");
        sr(32, 4, 1);
        step(1'b1);
        r = cyc;
        step(1'b1);
        pl_rst = 1'b1;
        step(1'b1);
        pl_rst = 1'b0;
        chk("t7_gated", sysref_gated, 0);
        chk("t7_busy", busy, 0);
        chk("t7_locked", locked, 0);
        chk("t7_period", period, 0);
        exp_q.push_back('{t: r, w: 2});
        step(1'b1);
        for (int i = 0; i < 28; i++) step(1'b0);
        for (int i = 0; i < 3; i++) sr(32, 4, 0);
        sb_cmp("t7_sb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sysref_gate_ctrl.md
# sysref_gate_ctrl

Sequencer for the PL SYSREF path used in multi-tile sync. It takes the SYSREF already captured into the PL clock domain and measures its period until it is stable. It then passes a programmed number of complete SYSREF pulses to the RF-ADC/RF-DAC sync logic and closes the gate so no further SYSREF reaches the converters. It sits directly after the PL SYSREF capture flop and before the converter SYSREF inputs, controlled by software via start/abort and status outputs.

## Interface
- CNT_W, 16: width of period counter, `period` output and timeout compare.
- TOL, 1: max allowed |period − reference| in pl_clk cycles.
- STABLE, 4: consecutive in-tolerance periods required for lock (≥1).
- MAX_MISS, 8: out-of-tolerance periods tolerated during MEASURE before error (≥1).
- TIMEOUT, 65535: cycles without a rising edge before error (≤ 2^CNT_W − 1).

- pl_clk  in  1  PL clock, same domain as the captured SYSREF.
- pl_rst  in  1  reset; synchronous, active-high.
- sysref_in  in  1  captured SYSREF, synchronous to pl_clk.
- start  in  1  single-cycle pulse; begin sequence (accepted in IDLE, DONE, ERR).
- abort  in  1  return to IDLE from any state; priority over start.
- release_count  in  8  complete pulses to pass; sampled on accepted start.
- sysref_gated  out  1  gated SYSREF to converters (registered).
- busy  out  1  high in MEASURE or GATE.
- locked  out  1  period lock achieved for the current sequence.
- done  out  1  high in DONE.
- error  out  1  high in ERR.
- err_code  out  2  0 none, 1 edge timeout, 2 no lock, 3 drift during GATE.
- period  out  CNT_W  locked reference period in pl_clk cycles.

## Operation
- Edge detect: `sysref_d` is the registered `sysref_in`. Rise = sysref_in & ~sysref_d. Fall = ~sysref_in & sysref_d.
- States: IDLE, MEASURE, GATE, DONE, ERR. Reset → IDLE, all outputs 0, `period` 0.
- IDLE/DONE/ERR + start (no abort) → MEASURE. The transition:
  - latches release_count,
  - clears locked, err_code, match_cnt, miss_cnt and the first-edge flag,
  - loads cnt with 0.
- cnt: loaded with 1 on every rise, otherwise increments, saturating at TIMEOUT. If cnt == TIMEOUT in MEASURE or GATE → ERR, code 1.
- MEASURE:
  - First rise only arms measurement; no period is taken.
  - Every later rise yields p = cnt.
  - First p loads `ref` with match_cnt = 0.
  - If |p − ref| ≤ TOL, match_cnt++.
  - Otherwise ref ← p, match_cnt ← 0, miss_cnt++. When miss_cnt reaches MAX_MISS → ERR, code 2.
  - When match_cnt reaches STABLE: locked ← 1, `period` ← ref. Next state is GATE, or DONE if the latched release_count == 0.
- GATE:
  - `pass` sets on the first GATE cycle with sysref_in == 0, so the lock-confirming pulse is never passed and no runt pulse is output.
  - While pass is set, each rise increments pulse_cnt.
  - On the fall after pulse_cnt == release_count: pass clears and the state goes to DONE.
  - Each rise in GATE is also drift-checked. If |cnt − ref| > TOL → ERR, code 3.
- sysref_gated ← sysref_in & pass & (state == GATE), registered.
- ERR: locked ← 0; error and err_code held until start or abort.
- abort (any state) → IDLE next cycle. Clears pass, locked, err_code. sysref_gated is 0 from the cycle after abort is sampled.
- start while busy is ignored. Simultaneous start+abort: abort wins.

## Timing
- sysref_gated lags sysref_in by exactly 1 cycle while passing. Pulse width and spacing are preserved.
- Rise detected in the cycle where sysref_in first reads 1 (i.e. sysref_d still 0).
- Period = cycles between consecutive rise detections. Rises at cycles 0 and 10 give p = 10.
- locked, `period` and the state change are visible the cycle after the lock-confirming rise.
- done/error are asserted the cycle after the triggering condition, as levels.
- Reset mid-sequence: next cycle equals post-reset state. No pulse is emitted after the reset cycle.

## Test plan
- Lock and pass: SYSREF period 32, high 4 cycles, release_count = 3, TOL = 1, STABLE = 4.
  - locked rises the cycle after the 6th rise; period = 32.
  - Exactly 3 pulses of width 4, spaced 32, appear on sysref_gated with 1-cycle latency; then done = 1.
  - No further gated pulses across 10 more SYSREF periods.
- Jitter tolerance: periods 32, 33, 31, 32, 33 → lock. A period of 35 during MEASURE resets match_cnt and reloads ref = 35.
- No lock: alternating periods 20/40 with MAX_MISS = 8 → error = 1, err_code = 2; sysref_gated never asserted.
- Timeout: TIMEOUT = 100, SYSREF stops after lock while in GATE → error, err_code = 1 at cnt == 100. sysref_gated stays 0.
- Drift in GATE: period changes from 32 to 40 after lock → err_code = 3 on that rise. The drifted pulse is not output, since the gate closes from the error cycle.
- Abort/reset: abort asserted mid-pulse in GATE → sysref_gated 0 next cycle, busy = 0, locked = 0. Same check with pl_rst. release_count = 0 → done right after lock with no gated pulses.
